fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 tb/tb_fifo_uart_tx.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a first-word-fall-through FIFO.
// 16x oversampled timing via s_tick. Frames are LSB first, with one start bit
// and a stop bit that lasts SB_TICK ticks.
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // The tick counter is 4 bits, and grows only when the stop bit needs more than 16 ticks.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] b, b_n;
  logic            tx_reg, tx_n;
  logic            done_c, rd_c;

  // State and datapath registers. Reset wins over everything and drops any popped word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_n;
      s      <= s_n;
      n      <= n_n;
      b      <= b_n;
      tx_reg <= tx_n;
    end
  end

  // Next-state and datapath update. Nothing advances without s_tick once a frame is running.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    done_c  = 1'b0;
    rd_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          rd_c    = 1'b1;
          b_n     = r_data;
          s_n     = '0;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            state_n = DATA;
            s_n     = '0;
            n_n     = '0;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n = '0;
            b_n = b >> 1;
            if (n == NW'(DBIT - 1)) state_n = STOP;
            else                    n_n     = n + NW'(1);
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            done_c  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs. tx_reg is loaded from the next state, so the line changes on the same
  // edge as the state. Strobes are masked while reset is asserted.
  always_comb begin
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = b_n[0];
      default: tx_n = 1'b1;
    endcase
    rd           = rd_c & ~reset;
    tx_done_tick = done_c & ~reset;
    tx_busy      = (state != IDLE);
    tx           = tx_reg;
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with DBIT=8 and SB_TICK=16. The line is sampled on every
// s_tick, which gives 16 start samples, 16 samples per data bit and 16 stop samples.
module tb_fifo_uart_tx;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd, tx, tx_busy, tx_done_tick;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_div = 1;
  int last_pop = 0;

  fifo_uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .empty(empty), .r_data(r_data),
    .rd(rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  // Cycle counter and tick generator. s_tick is high on every tick_div-th cycle.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    s_tick = ((cyc % tick_div) == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one frame. The call starts at posedge+1 with the DUT in IDLE.
  // If abort_k is reached, the task returns at the negedge after that many ticks.
  task automatic frame(input string tag, input logic [7:0] d, input bit rnd,
                       input int abort_k, output logic [7:0] got);
    int k, c0, done_k, done_c;
    bit ok_busy, ok_rd, ok_start, ok_stop, done_seen;
    k = 0; done_k = -1; done_c = -1; got = 8'h00;
    ok_busy = 1; ok_rd = 1; ok_start = 1; ok_stop = 1; done_seen = 0;
    empty = 1'b0; r_data = d;
    @(negedge clk);
    chk({tag, "_pop_rd"}, 32'(rd), 32'd1);
    chk({tag, "_pop_idle"}, 32'(tx_busy), 32'd0);
    c0 = cyc; last_pop = cyc;
    for (int i = 0; i < 200 * tick_div && !done_seen; i++) begin
      @(posedge clk); #1;
      if (rnd) begin empty = 1'($urandom_range(0, 1)); r_data = 8'($urandom); end
      else empty = 1'b1;
      @(negedge clk);
      if (tx_busy !== 1'b1) ok_busy = 0;
      if (rd !== 1'b0) ok_rd = 0;
      if (s_tick) begin
        if (k < 16 && tx !== 1'b0) ok_start = 0;
        if (k >= 144 && tx !== 1'b1) ok_stop = 0;
        if (k >= 16 && k < 144 && ((k - 16) % 16) == 8) got[(k - 16) / 16] = tx;
        if (tx_done_tick) begin done_seen = 1; done_k = k; done_c = cyc - c0; end
        k++;
        if (k == abort_k) return;
      end else if (tx_done_tick) begin
        done_seen = 1; done_k = -2;
      end
    end
    chk({tag, "_busy"}, 32'(ok_busy), 32'd1);
    chk({tag, "_no_rd"}, 32'(ok_rd), 32'd1);
    chk({tag, "_start"}, 32'(ok_start), 32'd1);
    chk({tag, "_stop"}, 32'(ok_stop), 32'd1);
    chk({tag, "_byte"}, 32'(got), 32'(d));
    chk({tag, "_done_tick"}, 32'(done_k), 32'd159);
    if (tick_div == 1) chk({tag, "_done_clks"}, 32'(done_c), 32'd160);
    @(posedge clk); #1;
    empty = 1'b1;
  endtask

  initial begin
    logic [7:0] got;
    int p1;
    bit ok_a, ok_b, ok_c;

    // Reset state. rd must stay low while reset is high, even with data waiting.
    reset = 1'b1; empty = 1'b0; r_data = 8'h55;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done_tick), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; empty = 1'b1;

    // Empty FIFO for 1000 clocks: the DUT should not pop and the line should stay idle.
    ok_a = 1; ok_b = 1; ok_c = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd !== 1'b0) ok_a = 0;
      if (tx !== 1'b1) ok_b = 0;
      if (tx_busy !== 1'b0) ok_c = 0;
    end
    chk("empty_rd", 32'(ok_a), 32'd1);
    chk("empty_tx", 32'(ok_b), 32'd1);
    chk("empty_busy", 32'(ok_c), 32'd1);
    @(posedge clk); #1;

    // Single byte with s_tick tied high.
    frame("a5", 8'hA5, 0, -1, got);

    // Back-to-back frames. The pop is 1 cycle, then 16 + 128 + 16 frame cycles,
    // then 1 IDLE cycle that pops again, so the pops are 161 cycles apart.
    frame("b2b0", 8'h00, 0, -1, got);
    p1 = last_pop;
    frame("b2b1", 8'hFF, 0, -1, got);
    chk("b2b_gap", 32'(last_pop - p1), 32'd161);

    // Slow tick: s_tick on every 4th cycle, so each bit lasts 64 clocks.
    tick_div = 4;
    frame("slow", 8'hA5, 0, -1, got);
    tick_div = 1;
    @(posedge clk); #1;

    // Inputs change randomly after the pop. The sent byte should be the popped value.
    frame("rnd", 8'h5A, 1, -1, got);

    // Mid-frame reset during data bit 3, which spans ticks 64..79.
    frame("abort", 8'h3C, 0, 70, got);
    @(posedge clk); #1;
    reset = 1'b1; empty = 1'b0; r_data = 8'h11;
    @(negedge clk);
    chk("abort_rd_hi", 32'(rd), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_rd_idle", 32'(rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; empty = 1'b1;
    ok_a = 1; ok_b = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_done_tick !== 1'b0) ok_a = 0;
      if (tx !== 1'b1) ok_b = 0;
    end
    chk("abort_no_done", 32'(ok_a), 32'd1);
    chk("abort_idle_tx", 32'(ok_b), 32'd1);
    @(posedge clk); #1;
    frame("after", 8'h11, 0, -1, got);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
